// File: rtl/mem_pkg.sv
// Shared types for the MEM-stage load/store sequencer: load_mode encodings,
// FSM states and default bus widths.
package mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    LM_WORD   = 2'b00,
    LM_HALF_S = 2'b01,
    LM_HALF_U = 2'b10,
    LM_BYTE_S = 2'b11
  } load_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic is_half(input load_mode_e mode);
    return (mode == LM_HALF_S) || (mode == LM_HALF_U);
  endfunction

endpackage

// File: rtl/load_extender.sv
// Little-endian lane select and sign/zero extension of a loaded bus word.
// Optional LOAD_BYTE_EN makes load_mode 11 a signed byte load; otherwise 11 is a word.
module load_extender
  import mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_lo_i,
  input  load_mode_e        load_mode_i,
  output logic [DATA_W-1:0] data_o
);

  logic [15:0] half;

`ifdef LOAD_BYTE_EN
  logic [7:0] byte_lane;
  always_comb byte_lane = word_i[{addr_lo_i, 3'b000} +: 8];
`else
  // Byte offset only matters for byte loads.
  logic unused_addr_bit;
  assign unused_addr_bit = addr_lo_i[0];
`endif

  // NOTE: every variable gets a default before the case, so no path infers a latch.
  always_comb begin
    half   = word_i[{addr_lo_i[1], 4'b0000} +: 16];
    data_o = word_i;
    case (load_mode_i)
      LM_HALF_S: data_o = {{(DATA_W-16){half[15]}}, half};
      LM_HALF_U: data_o = {{(DATA_W-16){1'b0}}, half};
`ifdef LOAD_BYTE_EN
      LM_BYTE_S: data_o = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
`endif
      default:   data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: request/ack bus transaction, pipeline stall,
// load extension, alignment fault and timeout. Optional feature macro: LOAD_BYTE_EN.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        load_mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  load_mode_e        mode_in, mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, load_data_q, ext_data;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q, bus_req_q, misalign_q, bus_err_q;
  logic              access_req, aligned, start, timeout_hit;

  assign mode_in    = load_mode_e'(load_mode);
  assign access_req = mem_read | mem_write;

  always_comb begin
    aligned = (addr[1:0] == 2'b00);
    if (is_half(mode_in)) aligned = ~addr[0];
`ifdef LOAD_BYTE_EN
    if (mode_in == LM_BYTE_S) aligned = 1'b1;
`endif
  end

  assign start = (state_q == IDLE) && access_req && aligned;

  // Abort fires in the ACCESS cycle that would make the no-ack count reach TIMEOUT_CYCLES.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == ACCESS) && !bus_ack &&
                       (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) state_d = ACCESS;
      end
      ACCESS: begin
        stall = 1'b1;
        if (bus_ack || timeout_hit) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked blocks use non-blocking (<=) only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the synchronous reset also clears the datapath registers, since bus_addr,
      // bus_wdata and load_data are visible outputs with defined reset values.
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= LM_WORD;
      we_q        <= 1'b0;
      bus_req_q   <= 1'b0;
      load_data_q <= '0;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      misalign_q <= (state_q == IDLE) && access_req && !aligned;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start) begin
            addr_q    <= addr;
            wdata_q   <= write_data;
            mode_q    <= mode_in;
            we_q      <= mem_write;
            bus_req_q <= 1'b1;
          end
        end
        ACCESS: begin
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            if (!we_q) load_data_q <= ext_data;
          end else if (timeout_hit) begin
            bus_req_q   <= 1'b0;
            load_data_q <= '0;
            bus_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  load_extender #(.DATA_W(DATA_W)) u_load_extender (
    .word_i      (bus_rdata),
    .addr_lo_i   (addr_q[1:0]),
    .load_mode_i (mode_q),
    .data_o      (ext_data)
  );

  assign bus_req      = bus_req_q;
  assign bus_we       = bus_req_q & we_q;
  assign bus_addr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus_wdata    = wdata_q;
  assign load_data    = load_data_q;
  assign load_valid   = (state_q == DONE) && !we_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a driver pushes expected bus and
// write-back events, an independent monitor pops and compares them.
module tb_mem_access_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [1:0]  load_mode;
  logic [31:0] addr, write_data;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid, misalign_err, bus_err;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .load_mode    (load_mode),
    .addr         (addr),
    .write_data   (write_data),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .stall        (stall),
    .load_data    (load_data),
    .load_valid   (load_valid),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    bit          err;
    bit          mis;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  resp_t resp_q[$];
  bus_t  bus_q[$];
  resp_t mon_r;
  bus_t  mon_b;
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none (t=%0t)", name, $time);
  endtask

  // Reference model: alignment and extension rules computed with plain arithmetic.
  function automatic bit ref_aligned(input logic [1:0] mode, input logic [31:0] a);
`ifdef LOAD_BYTE_EN
    if (mode == 2'b11) return 1'b1;
`endif
    if (mode == 2'b01 || mode == 2'b10) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] mode, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] v;
`ifdef LOAD_BYTE_EN
    if (mode == 2'b11) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      return (v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
    end
`endif
    if (mode == 2'b01 || mode == 2'b10) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (mode == 2'b01 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    return w;
  endfunction

  // Monitor: pops an expectation whenever the DUT shows a bus handshake or a write-back event.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req && bus_ack) begin
        if (bus_q.size() == 0) unexpected("bus_txn");
        else begin
          mon_b = bus_q.pop_front();
          check("bus_we", 32'(bus_we), 32'(mon_b.we));
          check("bus_addr", bus_addr, mon_b.addr);
          if (mon_b.we) check("bus_wdata", bus_wdata, mon_b.wdata);
        end
      end
      if (load_valid || bus_err || misalign_err) begin
        if (resp_q.size() == 0) unexpected("wb_event");
        else begin
          mon_r = resp_q.pop_front();
          check("wb_flags", {29'd0, load_valid, bus_err, misalign_err},
                {29'd0, mon_r.valid, mon_r.err, mon_r.mis});
          if (mon_r.valid) check("load_data", load_data, mon_r.data);
        end
      end
    end
  end

  // Issue one instruction starting just after a rising edge; ack_lat = ACCESS cycle of the ack, 0 = never.
  task automatic issue(input bit rd, input bit wr, input logic [1:0] mode, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdata, input int ack_lat);
    int n_stall;
    int k;
    mem_read   = rd;
    mem_write  = wr;
    load_mode  = mode;
    addr       = a;
    write_data = wd;
    if (!ref_aligned(mode, a)) begin
      resp_q.push_back('{valid: 1'b0, err: 1'b0, mis: 1'b1, data: 32'd0});
      @(negedge clk);
      check("misalign_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk);
      check("misalign_no_req", 32'(bus_req), 32'd0);
      @(posedge clk);
      #1;
      return;
    end
    if (!wr) begin
      if (ack_lat > 0) resp_q.push_back('{valid: 1'b1, err: 1'b0, mis: 1'b0, data: ref_load(mode, a, rdata)});
      else             resp_q.push_back('{valid: 1'b1, err: 1'b1, mis: 1'b0, data: 32'd0});
    end else if (ack_lat == 0) begin
      resp_q.push_back('{valid: 1'b0, err: 1'b1, mis: 1'b0, data: 32'd0});
    end
    if (ack_lat > 0) bus_q.push_back('{we: wr, addr: a & ~32'd3, wdata: wd});
    @(negedge clk);
    n_stall = stall ? 1 : 0;
    k = 0;
    while (k < 64) begin
      k++;
      @(posedge clk);
      #1;
      bus_ack   = (k == ack_lat);
      bus_rdata = (k == ack_lat) ? rdata : $urandom;
      @(negedge clk);
      if (!stall) break;
      n_stall++;
    end
    check("stall_cycles", n_stall, (ack_lat > 0) ? ack_lat + 1 : TMO + 1);
    @(posedge clk);
    #1;
    bus_ack   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic idle(input int n, input bit noise);
    repeat (n) begin
      bus_ack   = noise ? 1'($urandom % 2) : 1'b0;
      bus_rdata = $urandom;
      @(posedge clk);
      #1;
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst        = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    load_mode  = 2'b00;
    addr       = 32'd0;
    write_data = 32'd0;
    bus_rdata  = 32'd0;
    bus_ack    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_load_data", load_data, 32'd0);
    @(posedge clk);
    #1;

    issue(1'b1, 1'b0, 2'b00, 32'h100, 32'h0, 32'hDEAD_BEEF, 3);
    issue(1'b1, 1'b0, 2'b01, 32'h102, 32'h0, 32'h8001_1234, 2);
    issue(1'b1, 1'b0, 2'b10, 32'h102, 32'h0, 32'h8001_1234, 1);
    issue(1'b1, 1'b0, 2'b01, 32'h100, 32'h0, 32'h8001_1234, 2);
    issue(1'b0, 1'b1, 2'b00, 32'h204, 32'hCAFE_0001, 32'h0, 1);
    issue(1'b1, 1'b0, 2'b00, 32'h101, 32'h0, 32'h0, 1);
    issue(1'b1, 1'b0, 2'b00, 32'h108, 32'h0, 32'h0, 0);
    issue(1'b1, 1'b0, 2'b11, 32'h103, 32'h0, 32'h80FF_FFFF, 2);
    issue(1'b1, 1'b1, 2'b00, 32'h040, 32'h1234_5678, 32'h0, 1);
    idle(2, 1'b1);

    // Reset in the middle of an ACCESS, then a late ack that must be ignored.
    mem_read  = 1'b1;
    load_mode = 2'b00;
    addr      = 32'h300;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst      = 1'b1;
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_bus_req", 32'(bus_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("late_ack_no_valid", 32'(load_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    for (int i = 0; i < 80; i++) begin
      bit          rd, wr;
      logic [1:0]  mode;
      logic [31:0] a;
      int          lat;
      wr   = ($urandom % 3) == 0;
      rd   = !wr || (($urandom % 4) == 0);
      mode = 2'($urandom);
      a    = $urandom;
      if (($urandom % 3) != 0) a[1:0] = 2'b00;
      lat  = (($urandom % 10) == 0) ? 0 : int'($urandom_range(1, 5));
      issue(rd, wr, mode, a, $urandom, $urandom, lat);
      idle(int'($urandom_range(0, 2)), 1'b1);
    end

    idle(4, 1'b0);
    check("resp_q_drained", resp_q.size(), 32'd0);
    check("bus_q_drained", bus_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
